// File: rtl/booth_r4_multiplier_pkg.sv
// Shared types for the radix-4 Booth multiplier.
//   state_e      : controller state encoding (IDLE/EXEC/DONE, 11 illegal)
//   booth_sel_e  : Booth digit selection for one 3-bit recoding group
//   booth_sel()  : maps a {x[2i+1], x[2i], x[2i-1]} group to its digit
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_sel_e;

  function automatic booth_sel_e booth_sel(input logic [2:0] grp);
    booth_sel_e sel;
    case (grp)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;  // 000, 111
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_multiplier_if.sv
// Operand/result bundle for the Booth multiplier.
//   start, is_signed, multiplicand, multiplier : requester -> multiplier
//   busy, done, product_hi, product_lo         : multiplier -> requester
// master = requester side, slave = multiplier side.
interface booth_r4_multiplier_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, done, product_hi, product_lo
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, done, product_hi, product_lo
  );
endinterface

// File: rtl/booth_r4_multiplier_recoder.sv
// Radix-4 Booth recoder: one 3-bit group -> digit control flags.
//   grp_i  : {x[1], x[0], x_-1}
//   neg_o  : subtract the selected multiple
//   two_o  : selected multiple is 2Y (else Y)
//   zero_o : digit is 0, add nothing
module booth_r4_recoder
  import mult_pkg::*;
(
  input  logic [2:0] grp_i,
  output logic       neg_o,
  output logic       two_o,
  output logic       zero_o
);
  booth_sel_e sel;

  always_comb begin
    sel    = booth_sel(grp_i);
    neg_o  = (sel == NEG1) || (sel == NEG2);
    two_o  = (sel == POS2) || (sel == NEG2);
    zero_o = (sel == ZERO);
  end
endmodule

// File: rtl/booth_r4_multiplier.sv
// Iterative radix-4 Booth multiplier, one digit per clock.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of booth_r4_multiplier_if (start/operands in,
//              busy/done/product out)
// start in IDLE latches operands; N_ITER = WIDTH/2+1 EXEC cycles follow,
// then one DONE cycle with done=1 and the new product registered.
module booth_r4_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   reset_n,
  booth_r4_multiplier_if.slave  bus
);
  // Operands carry two extra bits so the unsigned case still ends with a
  // non-negative top digit; the accumulator needs one more for the 2Y term.
  localparam int W2     = WIDTH + 2;
  localparam int AW     = W2 + 1;
  localparam int N_ITER = WIDTH / 2 + 1;
  localparam int CW     = $clog2(N_ITER + 1);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("booth_r4_multiplier: WIDTH must be even and >= 4");
  end

  state_e           state_q, state_d;
  logic [AW-1:0]    a_q;
  logic [W2-1:0]    x_q, y_q;
  logic             x1_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] prod_hi_q, prod_lo_q;

  logic             neg, two, zero, last;
  logic [AW-1:0]    y_ext, mag, term, sum, a_nxt;
  logic [W2-1:0]    x_nxt;
  logic [W2-1:0]    op_y, op_x;

  booth_r4_recoder u_rec (
    .grp_i  ({x_q[1:0], x1_q}),
    .neg_o  (neg),
    .two_o  (two),
    .zero_o (zero)
  );

  // One Booth step: A += digit*Y, then {A,X} >>>= 2.
  always_comb begin
    y_ext = {y_q[W2-1], y_q};
    mag   = two ? (y_ext << 1) : y_ext;
    term  = zero ? '0 : (neg ? -mag : mag);
    sum   = a_q + term;
    a_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
    x_nxt = {sum[1:0], x_q[W2-1:2]};
    last  = (cnt_q == CW'(N_ITER - 1));
  end

  always_comb begin
    op_y = bus.is_signed ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                         : {2'b00, bus.multiplicand};
    op_x = bus.is_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                         : {2'b00, bus.multiplier};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = bus.start ? EXEC : IDLE;
      EXEC:    state_d = last ? DONE : EXEC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      x1_q      <= 1'b0;
      cnt_q     <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          a_q   <= '0;
          x_q   <= op_x;
          y_q   <= op_y;
          x1_q  <= 1'b0;
          cnt_q <= '0;
        end
        EXEC: begin
          a_q   <= a_nxt;
          x_q   <= x_nxt;
          x1_q  <= x_q[1];
          cnt_q <= cnt_q + CW'(1);
          // Low 2*WIDTH bits of the final {A,X}: all of X plus low A bits.
          if (last) {prod_hi_q, prod_lo_q} <= {a_nxt[WIDTH-3:0], x_nxt};
        end
        DONE: ;
        default: begin
          a_q   <= '0;
          x_q   <= '0;
          y_q   <= '0;
          x1_q  <= 1'b0;
          cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.busy       = (state_q == EXEC);
  assign bus.done       = (state_q == DONE);
  assign bus.product_hi = prod_hi_q;
  assign bus.product_lo = prod_lo_q;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
module tb_booth_r4_multiplier;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  booth_r4_multiplier_if #(.WIDTH(32)) if32 ();
  booth_r4_multiplier_if #(.WIDTH(8))  if8  ();

  booth_r4_multiplier #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(if32));
  booth_r4_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(if8));

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] q32[$];
  logic [15:0] q8[$];
  logic        d32_prev = 1'b0, d8_prev = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int p;
    if (s) p = int'($signed(a)) * int'($signed(b));
    else   p = int'({24'b0, a}) * int'({24'b0, b});
    return p[15:0];
  endfunction

  // Scoreboard: every done pulse pops one expected product.
  always @(negedge clk) begin
    if (reset_n) begin
      if (if32.done) begin
        chk("done32_single_pulse", {63'b0, d32_prev}, 64'd0);
        if (q32.size() == 0) chk("done32_unexpected", 64'd1, 64'd0);
        else chk("prod32", {if32.product_hi, if32.product_lo}, q32.pop_front());
      end
      if (if8.done) begin
        chk("done8_single_pulse", {63'b0, d8_prev}, 64'd0);
        if (q8.size() == 0) chk("done8_unexpected", 64'd1, 64'd0);
        else chk("prod8", {48'b0, if8.product_hi, if8.product_lo}, {48'b0, q8.pop_front()});
      end
    end
    d32_prev <= if32.done;
    d8_prev  <= if8.done;
  end

  task automatic run32(input logic [31:0] y, input logic [31:0] x, input logic s,
                       input logic [63:0] exp);
    int e, nb;
    @(negedge clk);
    if32.multiplicand = y; if32.multiplier = x; if32.is_signed = s; if32.start = 1'b1;
    q32.push_back(exp);
    @(posedge clk); #1;
    if32.start = 1'b0;
    e = 0; nb = 0;
    while (!if32.done && e < 100) begin
      if (if32.busy) nb++;
      @(posedge clk); #1; e++;
    end
    chk("latency32", 64'(e), 64'd17);
    chk("busy_cycles32", 64'(nb), 64'd17);
    @(posedge clk); #1;
  endtask

  task automatic run8(input logic [7:0] y, input logic [7:0] x, input logic s);
    int e, nb;
    @(negedge clk);
    if8.multiplicand = y; if8.multiplier = x; if8.is_signed = s; if8.start = 1'b1;
    q8.push_back(ref8(y, x, s));
    @(posedge clk); #1;
    if8.start = 1'b0;
    e = 0; nb = 0;
    while (!if8.done && e < 50) begin
      if (if8.busy) nb++;
      @(posedge clk); #1; e++;
    end
    chk("latency8", 64'(e), 64'd5);
    chk("busy_cycles8", 64'(nb), 64'd5);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] y;
    logic [31:0] x;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vec[10];

  initial begin
    int e;
    vec[0] = '{32'd3,         32'd5,         1'b0, 64'h00000000_0000000F};
    vec[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 64'hFFFFFFFE_00000001};
    vec[2] = '{32'h80000000,  32'h80000000,  1'b1, 64'h40000000_00000000};
    vec[3] = '{32'hFFFFFFFF,  32'd7,         1'b1, 64'hFFFFFFFF_FFFFFFF9};
    vec[4] = '{32'h7FFFFFFF,  32'h80000000,  1'b1, 64'hC0000000_80000000};
    vec[5] = '{32'h80000000,  32'd2,         1'b0, 64'h00000001_00000000};
    vec[6] = '{32'hFFFFFFFD,  32'hFFFFFFFB,  1'b1, 64'h00000000_0000000F};
    vec[7] = '{32'hFFFFFFFF,  32'd1,         1'b0, 64'h00000000_FFFFFFFF};
    vec[8] = '{32'hFFFFFFFF,  32'd1,         1'b1, 64'hFFFFFFFF_FFFFFFFF};
    vec[9] = '{32'd0,         32'hFFFFFFFF,  1'b1, 64'h00000000_00000000};

    if32.start = 1'b0; if32.is_signed = 1'b0; if32.multiplicand = '0; if32.multiplier = '0;
    if8.start  = 1'b0; if8.is_signed  = 1'b0; if8.multiplicand  = '0; if8.multiplier  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'b0, if32.busy}, 64'd0);
    chk("reset_done", {63'b0, if32.done}, 64'd0);
    chk("reset_product", {if32.product_hi, if32.product_lo}, 64'd0);
    @(negedge clk); reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run32(vec[i].y, vec[i].x, vec[i].s, vec[i].exp);

    // start re-asserted with new operands during EXEC, then held across DONE.
    @(negedge clk);
    if32.multiplicand = 32'd6; if32.multiplier = 32'd9; if32.is_signed = 1'b0; if32.start = 1'b1;
    q32.push_back(64'd54);
    @(posedge clk); #1;
    if32.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if32.start = 1'b1; if32.multiplicand = 32'd100; if32.multiplier = 32'd100; if32.is_signed = 1'b1;
    @(posedge clk); #1;
    if32.start = 1'b0;
    e = 4;
    while (!if32.done && e < 100) begin @(posedge clk); #1; e++; end
    chk("latency32_restart_ignored", 64'(e), 64'd17);
    if32.start = 1'b1;  // during DONE: must be ignored
    @(posedge clk); #1;
    if32.start = 1'b0;
    chk("done_one_cycle", {63'b0, if32.done}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("start_in_done_ignored", {63'b0, if32.busy}, 64'd0);
    chk("product_holds", {if32.product_hi, if32.product_lo}, 64'd54);

    // Reset during EXEC cycle 5 aborts the operation.
    @(negedge clk);
    if32.multiplicand = 32'h12345; if32.multiplier = 32'h777; if32.is_signed = 1'b0; if32.start = 1'b1;
    @(posedge clk); #1;
    if32.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_before_abort", {63'b0, if32.busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {63'b0, if32.busy}, 64'd0);
    chk("abort_done", {63'b0, if32.done}, 64'd0);
    chk("abort_product", {if32.product_hi, if32.product_lo}, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (25) @(posedge clk);  // any done here is flagged as unexpected
    run32(32'd6, 32'd7, 1'b0, 64'd42);

    // WIDTH=8 random against the reference model, both modes.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 200; i++) run8(8'($urandom), 8'($urandom), m[0]);

    repeat (3) @(posedge clk);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
